// File: rtl/cce_cfg_loader_pkg.sv
// Shared definitions for the CCE boot-time configuration loader.
//   - MMIO command opcode and size encodings
//   - cfg block register addresses (freeze, CCE mode, microcode base)
//   - loader FSM state enum and the command header struct
package cce_cfg_loader_pkg;

   localparam logic [3:0] UC_WR   = 4'b0001;
   localparam logic [2:0] SIZE_8B = 3'b011;

   // Full-width constants; each user truncates them to its own paddr width.
   localparam logic [63:0] CFG_FREEZE_ADDR   = 64'h20_0008;
   localparam logic [63:0] CFG_CCE_MODE_ADDR = 64'h20_0600;
   localparam logic [63:0] CFG_UCODE_BASE    = 64'h20_8000;

   typedef enum logic [2:0] {
      RESET,
      SEND_FREEZE,
      SEND_UCODE,
      SEND_CCE_MODE,
      SEND_UNFREEZE,
      WAIT_CREDITS,
      DONE
   } cfg_state_e;

   // Header fields shared by every command; the width-dependent fields are
   // appended by the loader, which knows its own parameters.
   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] size;
   } io_cmd_hdr_s;

endpackage

// File: rtl/cce_ucode_rom.sv
// CCE microcode ROM, asynchronous read.
//   addr_i : instruction index (0 .. els_p-1)
//   data_o : instruction word at addr_i
// The image is supplied as a flat parameter (entry i at bits [i*width_p +: width_p])
// so the contents are constants at elaboration time and the ROM folds into logic.
module cce_ucode_rom #(
   parameter int els_p        = 256,
   parameter int width_p      = 48,
   parameter int addr_width_p = 8,
   parameter logic [els_p*width_p-1:0] init_p = '0
) (
   input  logic [addr_width_p-1:0] addr_i,
   output logic [width_p-1:0]      data_o
);

   always_comb begin
      data_o = init_p[int'(addr_i) * width_p +: width_p];
   end

endmodule

// File: rtl/cce_mmio_cfg_loader.sv
// Boot-time configuration master for one CCE.
// Issues freeze, microcode load, CCE mode and (optionally) unfreeze MMIO writes,
// waits for every write to be acknowledged, then raises done_o.
//   clk_i, reset_n_i  : clock, asynchronous active-low reset
//   lce_id_i          : copied into every command's payload field
//   io_cmd_o/_v_o     : command {opcode, size, lce_id, addr, data} and valid
//   io_cmd_yumi_i     : command consumed this cycle
//   io_resp_i/_v_i    : response (contents ignored) and valid; each returns one credit
//   io_resp_ready_o   : always ready
//   done_o            : sequence complete, sticky until reset
module cce_mmio_cfg_loader
   import cce_cfg_loader_pkg::*;
#(
   parameter int paddr_width_p         = 40,
   parameter int dword_width_p         = 64,
   parameter int lce_id_width_p        = 4,
   parameter int inst_width_p          = 48,
   parameter int inst_ram_els_p        = 256,
   parameter int inst_ram_addr_width_p = 8,
   parameter int skip_ram_init_p       = 0,
   parameter int clear_freeze_p        = 1,
   parameter int max_outstanding_p     = 4,
   parameter logic [inst_ram_els_p*inst_width_p-1:0] ucode_init_p = '0
) (
   input  logic                                                     clk_i,
   input  logic                                                     reset_n_i,
   input  logic [lce_id_width_p-1:0]                                lce_id_i,
   output logic [6+lce_id_width_p+paddr_width_p+dword_width_p:0]    io_cmd_o,
   output logic                                                     io_cmd_v_o,
   input  logic                                                     io_cmd_yumi_i,
   input  logic [6+lce_id_width_p+paddr_width_p+dword_width_p:0]    io_resp_i,
   input  logic                                                     io_resp_v_i,
   output logic                                                     io_resp_ready_o,
   output logic                                                     done_o
);

   localparam int cred_w = $clog2(max_outstanding_p + 1);

   typedef struct packed {
      io_cmd_hdr_s                hdr;
      logic [lce_id_width_p-1:0]  payload;
      logic [paddr_width_p-1:0]   addr;
      logic [dword_width_p-1:0]   data;
   } io_cmd_s;

   cfg_state_e                       state_r, state_n;
   logic [inst_ram_addr_width_p-1:0] idx_r, idx_n;
   logic [cred_w-1:0]                credits_r, credits_n;
   logic [inst_width_p-1:0]          rom_data;
   io_cmd_s                          cmd;
   logic                             sending, at_limit, fire, resp_take, last_idx;

   // Response contents carry nothing we need; only the valid is a credit.
   logic unused_resp;
   assign unused_resp = ^io_resp_i;

   cce_ucode_rom #(
      .els_p        (inst_ram_els_p),
      .width_p      (inst_width_p),
      .addr_width_p (inst_ram_addr_width_p),
      .init_p       (ucode_init_p)
   ) u_rom (
      .addr_i (idx_r),
      .data_o (rom_data)
   );

   assign sending   = (state_r == SEND_FREEZE)   || (state_r == SEND_UCODE) ||
                      (state_r == SEND_CCE_MODE) || (state_r == SEND_UNFREEZE);
   assign at_limit  = (credits_r == cred_w'(max_outstanding_p));
   assign fire      = io_cmd_v_o & io_cmd_yumi_i;
   // A response with nothing outstanding is dropped rather than underflowing.
   assign resp_take = io_resp_v_i && (credits_r != '0);
   assign last_idx  = (idx_r == inst_ram_addr_width_p'(inst_ram_els_p - 1));

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= RESET;
         idx_r   <= '0;
      end else begin
         state_r <= state_n;
         idx_r   <= idx_n;
      end
   end

   // Next-state logic: every send state advances only when its command is taken.
   always_comb begin
      state_n = state_r;
      idx_n   = idx_r;
      unique case (state_r)
         RESET:         state_n = SEND_FREEZE;
         SEND_FREEZE:   if (fire) state_n = (skip_ram_init_p != 0) ? SEND_CCE_MODE : SEND_UCODE;
         SEND_UCODE: begin
            if (fire) begin
               if (last_idx) begin
                  idx_n   = '0;
                  state_n = SEND_CCE_MODE;
               end else begin
                  idx_n = idx_r + 1'b1;
               end
            end
         end
         SEND_CCE_MODE: if (fire) state_n = (clear_freeze_p != 0) ? SEND_UNFREEZE : WAIT_CREDITS;
         SEND_UNFREEZE: if (fire) state_n = WAIT_CREDITS;
         WAIT_CREDITS:  if (credits_r == '0) state_n = DONE;
         DONE:          state_n = DONE;
         default:       state_n = RESET;
      endcase
   end

   // Outputs: decoded from registered state only, so the command never
   // depends on yumi and stays stable while it is being held.
   always_comb begin
      cmd             = '0;
      cmd.hdr.opcode  = UC_WR;
      cmd.hdr.size    = SIZE_8B;
      cmd.payload     = lce_id_i;
      unique case (state_r)
         SEND_FREEZE: begin
            cmd.addr = paddr_width_p'(CFG_FREEZE_ADDR);
            cmd.data = dword_width_p'(1);
         end
         SEND_UCODE: begin
            cmd.addr = paddr_width_p'(CFG_UCODE_BASE) + paddr_width_p'({idx_r, 3'b000});
            cmd.data[inst_width_p-1:0] = rom_data;
         end
         SEND_CCE_MODE: begin
            cmd.addr = paddr_width_p'(CFG_CCE_MODE_ADDR);
            cmd.data = dword_width_p'(1);
         end
         SEND_UNFREEZE: begin
            cmd.addr = paddr_width_p'(CFG_FREEZE_ADDR);
            cmd.data = '0;
         end
         default: ;
      endcase
      io_cmd_o        = cmd;
      io_cmd_v_o      = sending && !at_limit;
      done_o          = (state_r == DONE);
      io_resp_ready_o = 1'b1;
   end

   // Outstanding-command counter: a simultaneous issue and return cancel out.
   always_comb begin
      credits_n = credits_r;
      if (fire && !resp_take)      credits_n = credits_r + 1'b1;
      else if (!fire && resp_take) credits_n = credits_r - 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) credits_r <= '0;
      else            credits_r <= credits_n;
   end

endmodule

// File: tb/tb_cce_mmio_cfg_loader.sv
// Bench for cce_mmio_cfg_loader: three instances with different build options,
// random handshakes, and a reference model built from the command-sequence rules.
module tb_cce_mmio_cfg_loader;

   localparam int MAXO = 4;
   localparam int MW   = 115;
   localparam logic [47:0] ROM_V [4] = '{48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6,
                                         48'hC1C2_C3C4_C5C6, 48'hD1D2_D3D4_D5D6};
   localparam logic [191:0] UC_IMG = {ROM_V[3], ROM_V[2], ROM_V[1], ROM_V[0]};
   localparam int SKIP [3] = '{0, 1, 0};
   localparam int CLR  [3] = '{1, 1, 0};

   logic          clk = 1'b0;
   logic          rst_n  [3];
   logic [3:0]    lce    [3];
   logic [MW-1:0] cmd    [3];
   logic          v      [3];
   logic          yumi   [3];
   logic          resp_v [3];
   logic          ready  [3];
   logic          done   [3];
   logic [MW-1:0] resp_zero = '0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      cce_mmio_cfg_loader #(
         .paddr_width_p         (40),
         .dword_width_p         (64),
         .lce_id_width_p        (4),
         .inst_width_p          (48),
         .inst_ram_els_p        (4),
         .inst_ram_addr_width_p (2),
         .skip_ram_init_p       (SKIP[g]),
         .clear_freeze_p        (CLR[g]),
         .max_outstanding_p     (MAXO),
         .ucode_init_p          (UC_IMG)
      ) dut (
         .clk_i           (clk),
         .reset_n_i       (rst_n[g]),
         .lce_id_i        (lce[g]),
         .io_cmd_o        (cmd[g]),
         .io_cmd_v_o      (v[g]),
         .io_cmd_yumi_i   (yumi[g]),
         .io_resp_i       (resp_zero),
         .io_resp_v_i     (resp_v[g]),
         .io_resp_ready_o (ready[g]),
         .done_o          (done[g])
      );
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full boot of instance k. abort_after>0 returns right after that many
   // commands were taken; hold_at>=0 stalls yumi and responses for 10 cycles.
   task automatic run(input int k, input int abort_after, input int hold_at,
                      input int resp_start, input int yumi_pct, input int resp_pct);
      logic [39:0]   ea[$];
      logic [63:0]   ed[$];
      logic [MW-1:0] held;
      logic          held_v, exp_v, in_hold, dec;
      int            outst, fires, post_done;
      bit            started, fin;

      ea.push_back(40'h20_0008); ed.push_back(64'd1);
      if (SKIP[k] == 0)
         for (int i = 0; i < 4; i++) begin
            ea.push_back(40'h20_8000 + 40'(i * 8));
            ed.push_back({16'h0, ROM_V[i]});
         end
      ea.push_back(40'h20_0600); ed.push_back(64'd1);
      if (CLR[k] != 0) begin ea.push_back(40'h20_0008); ed.push_back(64'd0); end

      lce[k]    = (k == 2) ? 4'd5 : 4'($urandom);
      yumi[k]   = 1'b0;
      resp_v[k] = 1'b0;
      rst_n[k]  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_v", v[k], 0);
      chk("rst_done", done[k], 0);
      rst_n[k] = 1'b1;

      outst = 0; fires = 0; post_done = 0; started = 0; fin = 0;
      held = '0; held_v = 1'b0;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         if (cyc > 0) begin
            @(negedge clk);
            started = 1;
            dec = resp_v[k] && (outst > 0);
            if (yumi[k]) begin
               fires++;
               outst++;
               void'(ea.pop_front());
               void'(ed.pop_front());
            end
            if (dec) outst--;
            if (abort_after > 0 && fires == abort_after) return;
         end
         exp_v = started && (ea.size() > 0) && (outst < MAXO);
         chk("valid", v[k], exp_v);
         chk("resp_ready", ready[k], 1);
         if (v[k] && ea.size() > 0) begin
            chk("opcode",  cmd[k][114:111], 4'b0001);
            chk("size",    cmd[k][110:108], 3'b011);
            chk("payload", cmd[k][107:104], lce[k]);
            chk("addr",    cmd[k][103:64],  ea[0]);
            chk("data",    cmd[k][63:0],    ed[0]);
         end
         if (cyc == hold_at) begin held = cmd[k]; held_v = v[k]; end
         if (hold_at >= 0 && cyc > hold_at && cyc < hold_at + 10) begin
            chk("hold_cmd", cmd[k], held);
            chk("hold_v",   v[k],   held_v);
         end
         if (done[k]) begin
            chk("done_pending_cmds", ea.size(), 0);
            chk("done_credits", outst, 0);
            post_done++;
            if (post_done > 4) fin = 1;
         end
         in_hold   = (hold_at >= 0) && (cyc >= hold_at) && (cyc < hold_at + 10);
         yumi[k]   = v[k] && !in_hold && ($urandom_range(99) < yumi_pct);
         resp_v[k] = !in_hold && (cyc >= resp_start) && ($urandom_range(99) < resp_pct) &&
                     (outst > 0 || $urandom_range(9) == 0);
      end
      if (!fin) chk("timeout_done", done[k], 1);
      yumi[k]   = 1'b0;
      resp_v[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; yumi[k] = 1'b0; resp_v[k] = 1'b0; lce[k] = '0;
      end

      // Responses withheld at first: credit limit must cap issue at MAXO.
      run(0, 0, -1, 40, 100, 60);
      // Backpressure window early in the microcode phase.
      run(0, 0, 6, 0, 70, 50);
      // Reset in the middle of the microcode phase.
      run(0, 3, -1, 0, 100, 100);
      chk("pre_rst_v", v[0], 1);
      yumi[0] = 1'b0; resp_v[0] = 1'b0;
      #2 rst_n[0] = 1'b0;
      #1;
      chk("rst_async_v", v[0], 0);
      chk("rst_async_done", done[0], 0);
      @(negedge clk);
      run(0, 0, -1, 0, 60, 60);

      // Microcode skipped.
      run(1, 0, 4, 0, 100, 100);
      run(1, 0, -1, 5, 50, 40);

      // Tile left frozen, lce id 5.
      run(2, 0, -1, 10, 50, 40);
      for (int s = 0; s < 3; s++) run(s, 0, -1, 0, 40 + 20 * s, 30 + 20 * s);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
